// File: rtl/lcd_bus_rx_if.sv
// Bus bundle between an HD44780-style write-only LCD bus and the receiver.
// The receiver reports assembled bytes, display status and a character-buffer read port.
interface lcd_bus_rx_if;
  logic       sf_e;
  logic       e;
  logic       rs;
  logic       rw;
  logic       d, c, b, a;
  logic [3:0] rd_addr;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_rs;
  logic [6:0] cursor;
  logic       disp_on;
  logic       mode4;
  logic       nibble_err;
  logic [7:0] rd_data;

  modport master (
    output sf_e, e, rs, rw, d, c, b, a, rd_addr,
    input  byte_valid, byte_data, byte_rs, cursor, disp_on, mode4, nibble_err, rd_data
  );

  modport slave (
    input  sf_e, e, rs, rw, d, c, b, a, rd_addr,
    output byte_valid, byte_data, byte_rs, cursor, disp_on, mode4, nibble_err, rd_data
  );
endinterface

// File: rtl/lcd_bus_rx.sv
// Snoops a 4-bit LCD write bus, rebuilds bytes and mirrors a 16-entry
// character buffer plus cursor/display state of the controller.
module lcd_bus_rx #(
  parameter int TIMEOUT = 4194304
) (
  input  logic         clk,
  input  logic         rst_n,
  lcd_bus_rx_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_INIT8, S_HI, S_LO} state_t;

  state_t          r_state, w_next;
  logic            r_e, r_sf_e, r_rs, r_rw;
  logic [3:0]      r_nib;
  logic [3:0]      r_hi;
  logic [CW-1:0]   r_cnt;
  logic            r_byte_valid;
  logic [7:0]      r_byte_data;
  logic            r_byte_rs;
  logic [6:0]      r_cursor;
  logic            r_disp_on;
  logic            r_mode4;
  logic            r_inc;
  logic            r_nib_err;
  logic [7:0]      r_buf [16];

  logic            w_stb, w_vstb;
  logic            w_set4, w_ld_hi, w_accept, w_tmo;

  // Falling edge of the registered strobe; fields come from the cycle e was high.
  assign w_stb  = r_e & ~bus.e;
  assign w_vstb = w_stb & r_sf_e & ~r_rw;

  always_comb begin
    w_next   = r_state;
    w_set4   = 1'b0;
    w_ld_hi  = 1'b0;
    w_accept = 1'b0;
    w_tmo    = 1'b0;
    unique case (r_state)
      S_INIT8: if (w_vstb && r_nib == 4'h2 && !r_rs) begin
        w_set4 = 1'b1;
        w_next = S_HI;
      end
      S_HI: if (w_vstb) begin
        w_ld_hi = 1'b1;
        w_next  = S_LO;
      end
      S_LO: begin
        // A strobe landing on the expiry cycle still wins over the timeout.
        if (w_vstb) begin
          w_accept = 1'b1;
          w_next   = S_HI;
        end else if (r_cnt == CW'(1)) begin
          w_tmo  = 1'b1;
          w_next = S_HI;
        end
      end
      default: w_next = S_INIT8;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_INIT8;
      r_e          <= 1'b0;
      r_sf_e       <= 1'b0;
      r_rs         <= 1'b0;
      r_rw         <= 1'b0;
      r_nib        <= 4'h0;
      r_hi         <= 4'h0;
      r_cnt        <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'h00;
      r_byte_rs    <= 1'b0;
      r_cursor     <= 7'h00;
      r_disp_on    <= 1'b0;
      r_mode4      <= 1'b0;
      r_inc        <= 1'b1;
      r_nib_err    <= 1'b0;
      for (int i = 0; i < 16; i++) r_buf[i] <= 8'h20;
    end else begin
      r_e          <= bus.e;
      r_sf_e       <= bus.sf_e;
      r_rs         <= bus.rs;
      r_rw         <= bus.rw;
      r_nib        <= {bus.d, bus.c, bus.b, bus.a};
      r_state      <= w_next;
      r_byte_valid <= w_accept;
      r_nib_err    <= w_tmo;
      if (w_set4) r_mode4 <= 1'b1;
      if (w_ld_hi) begin
        r_hi  <= r_nib;
        r_cnt <= CW'(TIMEOUT);
      end else if (r_state == S_LO && !w_accept) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_accept) begin
        r_byte_data <= {r_hi, r_nib};
        r_byte_rs   <= r_rs;
      end
      // Byte decode happens at the end of the byte_valid cycle.
      if (r_byte_valid) begin
        if (r_byte_rs) begin
          if (r_cursor[6:4] == 3'b000) r_buf[r_cursor[3:0]] <= r_byte_data;
          r_cursor <= r_inc ? r_cursor + 7'd1 : r_cursor - 7'd1;
        end else if (r_byte_data == 8'h01) begin
          for (int i = 0; i < 16; i++) r_buf[i] <= 8'h20;
          r_cursor <= 7'h00;
          r_inc    <= 1'b1;
        end else if (r_byte_data[7:1] == 7'h01) begin
          r_cursor <= 7'h00;
        end else if (r_byte_data[7]) begin
          r_cursor <= r_byte_data[6:0];
        end else if (r_byte_data[7:3] == 5'h01) begin
          r_disp_on <= r_byte_data[2];
        end else if (r_byte_data[7:2] == 6'h01) begin
          r_inc <= r_byte_data[1];
        end
      end
    end
  end

  assign bus.byte_valid = r_byte_valid;
  assign bus.byte_data  = r_byte_data;
  assign bus.byte_rs    = r_byte_rs;
  assign bus.cursor     = r_cursor;
  assign bus.disp_on    = r_disp_on;
  assign bus.mode4      = r_mode4;
  assign bus.nibble_err = r_nib_err;
  assign bus.rd_data    = r_buf[bus.rd_addr];
endmodule

// File: tb/tb_lcd_bus_rx.sv
// Bench for lcd_bus_rx: directed vector table, timeout/reset corner sequences,
// and random byte traffic against a byte-level model of the controller state.
module tb_lcd_bus_rx;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_bus_rx_if bus();
  lcd_bus_rx #(.TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0, n_fail = 0;
  int n_valid = 0, n_err = 0;

  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1) n_valid++;
    if (bus.nibble_err === 1'b1) n_err++;
  end

  // Byte-level model of the controller
  int         m_cursor, m_inc, m_disp, m_nvalid, m_nerr, m_last_rs;
  logic [7:0] m_last;
  logic [7:0] m_buf [16];

  task automatic model_reset();
    m_cursor = 0; m_inc = 1; m_disp = 0; m_last = 8'h00; m_last_rs = 0;
    for (int i = 0; i < 16; i++) m_buf[i] = 8'h20;
  endtask

  task automatic model_byte(input int rs, input int b);
    m_nvalid++;
    m_last = b[7:0];
    m_last_rs = rs;
    if (rs != 0) begin
      if (m_cursor < 16) m_buf[m_cursor] = b[7:0];
      m_cursor = (m_cursor + ((m_inc != 0) ? 1 : 127)) % 128;
    end else if (b == 1) begin
      for (int i = 0; i < 16; i++) m_buf[i] = 8'h20;
      m_cursor = 0; m_inc = 1;
    end else if (b == 2 || b == 3) begin
      m_cursor = 0;
    end else if (b >= 128) begin
      m_cursor = b - 128;
    end else if (b >= 8 && b <= 15) begin
      m_disp = (b / 4) % 2;
    end else if (b >= 4 && b <= 7) begin
      m_inc = (b / 2) % 2;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic sf, input logic rs_i, input logic rw_i, input logic [3:0] nib);
    @(posedge clk); #1;
    bus.e = 1'b1; bus.sf_e = sf; bus.rs = rs_i; bus.rw = rw_i;
    {bus.d, bus.c, bus.b, bus.a} = nib;
    @(posedge clk); #1;
    bus.e = 1'b0;
  endtask

  task automatic send(input logic sf, input logic rs_i, input logic rw_i, input logic [7:0] b);
    strobe(sf, rs_i, rw_i, b[7:4]);
    strobe(sf, rs_i, rw_i, b[3:0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_rd(input string nm, input int addr, input logic [7:0] exp);
    bus.rd_addr = addr[3:0];
    #1;
    chk(nm, bus.rd_data, exp);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " cursor"}, bus.cursor, m_cursor);
    chk({tag, " disp_on"}, bus.disp_on, m_disp);
    chk({tag, " byte_data"}, bus.byte_data, m_last);
    chk({tag, " byte_rs"}, bus.byte_rs, m_last_rs);
    chk({tag, " valid_cnt"}, n_valid, m_nvalid);
    chk({tag, " err_cnt"}, n_err, m_nerr);
  endtask

  task automatic do_init();
    strobe(1, 0, 0, 4'h3);
    strobe(1, 0, 0, 4'h3);
    strobe(1, 0, 0, 4'h3);
    repeat (2) @(posedge clk); @(negedge clk);
    chk("init mode4 before 2", bus.mode4, 0);
    strobe(1, 0, 0, 4'h2);
    repeat (2) @(posedge clk); @(negedge clk);
    chk("init mode4 after 2", bus.mode4, 1);
    chk("init no byte_valid", n_valid, m_nvalid);
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] b;
    logic [6:0] cur;
    logic       disp;
    logic [3:0] ra;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b0, 8'h0C, 7'h00, 1'b1, 4'd0,  8'h20};
    tbl[1] = '{1'b0, 8'h01, 7'h00, 1'b1, 4'd5,  8'h20};
    tbl[2] = '{1'b1, 8'h23, 7'h01, 1'b1, 4'd0,  8'h23};
    tbl[3] = '{1'b0, 8'h8F, 7'h0F, 1'b1, 4'd0,  8'h23};
    tbl[4] = '{1'b1, 8'h31, 7'h10, 1'b1, 4'd15, 8'h31};
    tbl[5] = '{1'b1, 8'h32, 7'h11, 1'b1, 4'd15, 8'h31};
    tbl[6] = '{1'b0, 8'h04, 7'h11, 1'b1, 4'd1,  8'h20};
    tbl[7] = '{1'b0, 8'h80, 7'h00, 1'b1, 4'd0,  8'h23};
    tbl[8] = '{1'b1, 8'h30, 7'h7F, 1'b1, 4'd0,  8'h30};

    bus.e = 0; bus.sf_e = 0; bus.rs = 0; bus.rw = 0;
    {bus.d, bus.c, bus.b, bus.a} = 4'h0; bus.rd_addr = 4'h0;
    m_nvalid = 0; m_nerr = 0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst mode4", bus.mode4, 0);
    chk("rst byte_valid", bus.byte_valid, 0);
    chk("rst nibble_err", bus.nibble_err, 0);
    chk_model("rst");
    chk_rd("rst rd3", 3, 8'h20);

    do_init();

    // Directed table
    for (int i = 0; i < 9; i++) begin
      send(1, tbl[i].rs, 0, tbl[i].b);
      model_byte(tbl[i].rs, tbl[i].b);
      chk($sformatf("tbl%0d cursor", i), bus.cursor, tbl[i].cur);
      chk($sformatf("tbl%0d disp_on", i), bus.disp_on, tbl[i].disp);
      chk($sformatf("tbl%0d byte_data", i), bus.byte_data, tbl[i].b);
      chk($sformatf("tbl%0d byte_rs", i), bus.byte_rs, tbl[i].rs);
      chk($sformatf("tbl%0d valid_cnt", i), n_valid, i + 1);
      chk_rd($sformatf("tbl%0d rd", i), tbl[i].ra, tbl[i].rd);
      if (i == 1)
        for (int a = 0; a < 16; a++) chk_rd($sformatf("clear rd%0d", a), a, 8'h20);
    end

    // Ignored strobes: read cycles and disabled bus
    send(1, 0, 1, 8'h10);
    chk_model("rw1 ignored");
    send(0, 1, 0, 8'h55);
    chk_model("sf_e0 ignored");

    // Timeout discards a half byte, next pair is clean
    strobe(1, 1, 0, 4'h2);
    repeat (T + 3) @(posedge clk); @(negedge clk);
    m_nerr++;
    chk_model("timeout err");
    send(1, 1, 0, 8'h41);
    model_byte(1, 8'h41);
    chk_model("after timeout 0x41");

    // Low nibble exactly on the expiry cycle is accepted
    strobe(1, 1, 0, 4'h4);
    repeat (T - 2) @(posedge clk);
    strobe(1, 1, 0, 4'h2);
    repeat (3) @(posedge clk); @(negedge clk);
    model_byte(1, 8'h42);
    chk_model("expiry accept");

    // One cycle later is too late: error, then the late nibble times out too
    strobe(1, 1, 0, 4'h4);
    repeat (T - 1) @(posedge clk);
    strobe(1, 1, 0, 4'h3);
    repeat (T + 3) @(posedge clk); @(negedge clk);
    m_nerr += 2;
    chk_model("expiry late");

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      int kind, rsr, br, ra;
      kind = $urandom_range(0, 9);
      rsr  = $urandom_range(0, 1);
      br   = $urandom_range(0, 255);
      ra   = $urandom_range(0, 15);
      if (kind == 0) send(0, rsr[0], 0, br[7:0]);
      else if (kind == 1) send(1, rsr[0], 1, br[7:0]);
      else begin
        if (kind < 4) br = br % 16;
        send(1, rsr[0], 0, br[7:0]);
        model_byte(rsr, br);
      end
      chk_model($sformatf("rnd%0d", k));
      chk_rd($sformatf("rnd%0d rd", k), ra, m_buf[ra]);
    end
    for (int a = 0; a < 16; a++) chk_rd($sformatf("final rd%0d", a), a, m_buf[a]);

    // Reset in the middle of a byte
    send(1, 0, 0, 8'h0C);
    model_byte(0, 8'h0C);
    strobe(1, 1, 0, 4'h7);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    chk("midrst mode4", bus.mode4, 0);
    chk("midrst byte_valid", bus.byte_valid, 0);
    chk_model("midrst");
    for (int a = 0; a < 16; a++) chk_rd($sformatf("midrst rd%0d", a), a, 8'h20);
    repeat (T + 3) @(posedge clk); @(negedge clk);
    chk("midrst no err", n_err, m_nerr);
    do_init();
    send(1, 1, 0, 8'h55);
    model_byte(1, 8'h55);
    chk_model("post rst data");
    chk_rd("post rst rd0", 0, 8'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
